// File: rtl/puzzle_move_ctrl.sv
// 3x3 sliding-tile board controller: owns the board, scans loads for the blank, applies button moves.
// Optional macro PUZZLE_BTN_SYNC_EN inserts a 2-flop synchroniser on each button input.
module puzzle_move_ctrl #(
  parameter int CNT_W         = 10,
  parameter bit LOCK_ON_SOLVE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_l,
  input  logic             btn_r,
  input  logic             btn_u,
  input  logic             btn_d,
  input  logic             load,
  input  logic [11:0]      ld_r1,
  input  logic [11:0]      ld_r2,
  input  logic [11:0]      ld_r3,
  output logic [11:0]      r1,
  output logic [11:0]      r2,
  output logic [11:0]      r3,
  output logic [3:0]       blank_pos,
  output logic [CNT_W-1:0] move_cnt,
  output logic             busy,
  output logic             move_done,
  output logic             illegal,
  output logic             solved,
  output logic             err
);

  typedef enum logic [2:0] {IDLE, SCAN, READY, MOVE, CHECK, SOLVED, ERR} state_t;

  localparam logic [35:0] HOME_BOARD = 36'h123456780;

  state_t          state_reg;
  logic [3:0]      scan_idx_reg;
  logic [3:0]      scan_pos_reg;
  logic            found_reg;
  logic [3:0]      partner_reg;
  logic [3:0]      btn_q_reg;
  logic [3:0]      btn_raw;
  logic [3:0]      btn_s;
  logic [3:0]      press;
  logic [8:0][3:0] cell_w;
  logic [35:0]     ld_flat;
  logic [3:0]      scan_cell;
  logic [3:0]      partner_tile;
  logic [3:0]      row_base;
  logic [3:0]      col;
  logic            press_one;
  logic            mv_legal;
  logic [3:0]      mv_partner;
  logic            load_accept;
  logic            move_commit;
  logic            board_solved;
  logic            scan_zero;

  assign btn_raw = {btn_l, btn_r, btn_u, btn_d};

`ifdef PUZZLE_BTN_SYNC_EN
  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  assign btn_s = sync2_reg;
`else
  assign btn_s = btn_raw;
`endif

  // History updates in every state so a press during busy never resurfaces later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_q_reg <= '0;
    else     btn_q_reg <= btn_s;
  end

  assign press     = btn_s & ~btn_q_reg;
  assign press_one = (press != 4'd0) && ((press & (press - 4'd1)) == 4'd0);

  assign ld_flat     = {ld_r1, ld_r2, ld_r3};
  assign load_accept = load && (state_reg == IDLE || state_reg == READY ||
                                state_reg == SOLVED || state_reg == ERR);
  assign move_commit = (state_reg == MOVE);

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_cell
      logic [3:0] cell_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cell_reg <= HOME_BOARD[35-4*gi -: 4];
        end else if (load_accept) begin
          cell_reg <= ld_flat[35-4*gi -: 4];
        end else if (move_commit) begin
          if (blank_pos == 4'(gi))        cell_reg <= partner_tile;
          else if (partner_reg == 4'(gi)) cell_reg <= 4'd0;
        end
      end

      assign cell_w[gi] = cell_reg;
    end
  endgenerate

  assign r1 = {cell_w[0], cell_w[1], cell_w[2]};
  assign r2 = {cell_w[3], cell_w[4], cell_w[5]};
  assign r3 = {cell_w[6], cell_w[7], cell_w[8]};

  assign board_solved = ({r1, r2, r3} == HOME_BOARD);

  always_comb begin
    scan_cell    = 4'd0;
    partner_tile = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (scan_idx_reg == 4'(i)) scan_cell = cell_w[i];
      if (partner_reg == 4'(i))  partner_tile = cell_w[i];
    end
  end

  assign scan_zero = (scan_cell == 4'd0);

  // row_base is the index of column 0 in the blank's row.
  assign row_base = (blank_pos >= 4'd6) ? 4'd6 : ((blank_pos >= 4'd3) ? 4'd3 : 4'd0);
  assign col      = blank_pos - row_base;

  always_comb begin
    mv_legal   = 1'b0;
    mv_partner = blank_pos;
    case (press)
      4'b1000: begin mv_legal = (col != 4'd0);      mv_partner = blank_pos - 4'd1; end
      4'b0100: begin mv_legal = (col != 4'd2);      mv_partner = blank_pos + 4'd1; end
      4'b0010: begin mv_legal = (row_base != 4'd0); mv_partner = blank_pos - 4'd3; end
      4'b0001: begin mv_legal = (row_base != 4'd6); mv_partner = blank_pos + 4'd3; end
      default: begin mv_legal = 1'b0;               mv_partner = blank_pos;        end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      scan_idx_reg <= 4'd0;
      scan_pos_reg <= 4'd0;
      found_reg    <= 1'b0;
      partner_reg  <= 4'd0;
      blank_pos    <= 4'd8;
      move_cnt     <= '0;
      busy         <= 1'b0;
      move_done    <= 1'b0;
      illegal      <= 1'b0;
      solved       <= 1'b0;
      err          <= 1'b0;
    end else begin
      move_done <= 1'b0;
      illegal   <= 1'b0;
      if (load_accept) begin
        move_cnt     <= '0;
        solved       <= 1'b0;
        err          <= 1'b0;
        scan_idx_reg <= 4'd0;
        found_reg    <= 1'b0;
        busy         <= 1'b1;
        state_reg    <= SCAN;
      end else begin
        case (state_reg)
          SCAN: begin
            if (!found_reg && scan_zero) begin
              found_reg    <= 1'b1;
              scan_pos_reg <= scan_idx_reg;
            end
            if (scan_idx_reg == 4'd8) begin
              busy <= 1'b0;
              if (found_reg || scan_zero) begin
                blank_pos <= found_reg ? scan_pos_reg : scan_idx_reg;
                state_reg <= READY;
              end else begin
                err       <= 1'b1;
                state_reg <= ERR;
              end
            end else begin
              scan_idx_reg <= scan_idx_reg + 4'd1;
            end
          end
          READY, SOLVED: begin
            if ((state_reg == READY || !LOCK_ON_SOLVE) && press != 4'd0) begin
              if (press_one && mv_legal) begin
                partner_reg <= mv_partner;
                busy        <= 1'b1;
                state_reg   <= MOVE;
              end else begin
                illegal <= 1'b1;
              end
            end
          end
          MOVE: begin
            blank_pos <= partner_reg;
            if (move_cnt != '1) move_cnt <= move_cnt + CNT_W'(1);
            move_done <= 1'b1;
            state_reg <= CHECK;
          end
          CHECK: begin
            busy      <= 1'b0;
            solved    <= board_solved;
            state_reg <= board_solved ? SOLVED : READY;
          end
          default: begin
            state_reg <= state_reg;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_puzzle_move_ctrl.sv
// Scoreboard bench for puzzle_move_ctrl: expected move/illegal events are queued at stimulus time
// and popped by a monitor whenever the DUT pulses move_done or illegal.
module tb_puzzle_move_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
  logic        load = 1'b0;
  logic [11:0] ld_r1 = '0, ld_r2 = '0, ld_r3 = '0;
  logic [11:0] r1, r2, r3;
  logic [3:0]  blank_pos;
  logic [9:0]  move_cnt;
  logic        busy, move_done, illegal, solved, err;

  always #5 clk = ~clk;

  puzzle_move_ctrl #(.CNT_W(10), .LOCK_ON_SOLVE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
    .load(load), .ld_r1(ld_r1), .ld_r2(ld_r2), .ld_r3(ld_r3),
    .r1(r1), .r2(r2), .r3(r3), .blank_pos(blank_pos), .move_cnt(move_cnt),
    .busy(busy), .move_done(move_done), .illegal(illegal), .solved(solved), .err(err)
  );

  typedef struct {
    logic        is_move;
    logic [35:0] board;
    logic [3:0]  pos;
    logic [9:0]  cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [35:0] m_board;
  logic [3:0]  m_pos;
  logic [9:0]  m_cnt;
  bit          m_active;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_move(input logic [35:0] b, input logic [3:0] pos,
                                     input logic [3:0] dir, output bit legal,
                                     output logic [35:0] nb, output logic [3:0] np);
    int r, c, p;
    r = int'(pos) / 3;
    c = int'(pos) % 3;
    p = int'(pos);
    legal = 1'b0;
    case (dir)
      4'b1000: if (c > 0) begin legal = 1'b1; p = p - 1; end
      4'b0100: if (c < 2) begin legal = 1'b1; p = p + 1; end
      4'b0010: if (r > 0) begin legal = 1'b1; p = p - 3; end
      4'b0001: if (r < 2) begin legal = 1'b1; p = p + 3; end
      default: legal = 1'b0;
    endcase
    nb = b;
    if (legal) begin
      nb[35-4*int'(pos) -: 4] = b[35-4*p -: 4];
      nb[35-4*p -: 4]         = 4'd0;
    end
    np = 4'(p);
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (move_done || illegal)) begin
      $display("evt move_done=%0b illegal=%0b board=%09h pos=%0d cnt=%0d",
               move_done, illegal, {r1, r2, r3}, blank_pos, move_cnt);
      if (sb_q.size() == 0) begin
        check("unexpected_evt", {62'd0, move_done, illegal}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("evt_kind", {62'd0, move_done, illegal}, e.is_move ? 64'd2 : 64'd1);
        check("evt_board", {28'd0, r1, r2, r3}, {28'd0, e.board});
        check("evt_pos", {60'd0, blank_pos}, {60'd0, e.pos});
        check("evt_cnt", {54'd0, move_cnt}, {54'd0, e.cnt});
      end
    end
  end

  task automatic do_load(input logic [35:0] rows, input logic [3:0] exp_pos, input bit exp_err);
    int n;
    @(negedge clk);
    load = 1'b1;
    {ld_r1, ld_r2, ld_r3} = rows;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    $display("load board=%09h busy_cycles=%0d blank=%0d err=%0b", rows, n, blank_pos, err);
    check("busy_len", n, 9);
    check("load_err", {63'd0, err}, {63'd0, exp_err});
    check("load_cnt", {54'd0, move_cnt}, 64'd0);
    check("load_solved", {63'd0, solved}, 64'd0);
    check("load_board", {28'd0, r1, r2, r3}, {28'd0, rows});
    if (!exp_err) begin
      check("load_blank", {60'd0, blank_pos}, {60'd0, exp_pos});
      m_pos = exp_pos;
    end
    m_board  = rows;
    m_cnt    = '0;
    m_active = !exp_err;
  endtask

  task automatic expect_press(input logic [3:0] dir);
    bit          legal;
    logic [35:0] nb;
    logic [3:0]  np;
    exp_t        e;
    if (m_active) begin
      if ($countones(dir) != 1) legal = 1'b0;
      else model_move(m_board, m_pos, dir, legal, nb, np);
      if (legal) begin
        m_board = nb;
        m_pos   = np;
        m_cnt   = m_cnt + 10'd1;
        if (nb == 36'h123456780) m_active = 1'b0;
      end
      e.is_move = legal;
      e.board   = m_board;
      e.pos     = m_pos;
      e.cnt     = m_cnt;
      sb_q.push_back(e);
    end
  endtask

  task automatic press(input logic [3:0] dir, input int hold);
    expect_press(dir);
    @(negedge clk);
    {btn_l, btn_r, btn_u, btn_d} = dir;
    repeat (hold) @(negedge clk);
    {btn_l, btn_r, btn_u, btn_d} = 4'b0000;
    repeat (5) @(negedge clk);
    $display("press dir=%04b hold=%0d board=%09h pos=%0d cnt=%0d", dir, hold, {r1, r2, r3}, blank_pos, move_cnt);
    check("press_board", {28'd0, r1, r2, r3}, {28'd0, m_board});
    check("press_pos", {60'd0, blank_pos}, {60'd0, m_pos});
    check("press_cnt", {54'd0, move_cnt}, {54'd0, m_cnt});
    check("press_pending", sb_q.size(), 0);
  endtask

  initial begin
    m_board  = 36'h123456780;
    m_pos    = 4'd8;
    m_cnt    = '0;
    m_active = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_board", {28'd0, r1, r2, r3}, 64'h123456780);
    check("rst_pos", {60'd0, blank_pos}, 64'd8);
    check("rst_cnt", {54'd0, move_cnt}, 64'd0);
    check("rst_flags", {58'd0, busy, move_done, illegal, solved, err, 1'b0}, 64'd0);
    rst = 1'b0;

    // IDLE ignores presses
    press(4'b0100, 1);

    // One move to solved, then locked
    do_load(36'h123456708, 4'd7, 1'b0);
    press(4'b0100, 1);
    check("solved_flag", {63'd0, solved}, 64'd1);
    check("solved_board", {28'd0, r3}, 64'h780);
    press(4'b1000, 1);
    check("solved_hold", {63'd0, solved}, 64'd1);

    // Edge-of-board rejects
    do_load(36'h023145786, 4'd0, 1'b0);
    press(4'b1000, 1);
    press(4'b0010, 1);

    // Simultaneous presses, then a long hold makes one move
    do_load(36'h123405786, 4'd4, 1'b0);
    press(4'b1010, 1);
    press(4'b0001, 50);
    check("hold_r2", {52'd0, r2}, 64'h485);
    check("hold_r3", {52'd0, r3}, 64'h706);

    // No blank in load
    do_load(36'h123456789, 4'd0, 1'b1);
    press(4'b0100, 1);
    check("err_hold", {63'd0, err}, 64'd1);

    // Reload clears err; load during MOVE is ignored
    do_load(36'h123405786, 4'd4, 1'b0);
    check("err_clear", {63'd0, err}, 64'd0);
    expect_press(4'b0100);
    @(negedge clk);
    btn_r = 1'b1;
    @(negedge clk);
    btn_r = 1'b0;
    load  = 1'b1;
    {ld_r1, ld_r2, ld_r3} = 36'h123456780;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    $display("load_in_move board=%09h pos=%0d cnt=%0d", {r1, r2, r3}, blank_pos, move_cnt);
    check("lim_board", {28'd0, r1, r2, r3}, {28'd0, m_board});
    check("lim_cnt", {54'd0, move_cnt}, 64'd1);
    check("lim_busy", {63'd0, busy}, 64'd0);
    do_load(36'h103405786, 4'd1, 1'b0);

    // Async reset in the middle of a move
    do_load(36'h023145786, 4'd0, 1'b0);
    @(negedge clk);
    btn_r = 1'b1;
    @(negedge clk);
    btn_r = 1'b0;
    check("mid_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    $display("reset_mid_move board=%09h pos=%0d cnt=%0d busy=%0b", {r1, r2, r3}, blank_pos, move_cnt, busy);
    check("mid_rst_board", {28'd0, r1, r2, r3}, 64'h123456780);
    check("mid_rst_pos", {60'd0, blank_pos}, 64'd8);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    m_board  = 36'h123456780;
    m_pos    = 4'd8;
    m_cnt    = '0;
    m_active = 1'b0;
    press(4'b1000, 1);

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
